systolic_psum_drain: RTL and testbench
======================================

// Module: systolic_psum_drain
// PURPOSE
//  South-edge drain for the weight-stationary systolic array: captures the bottom-row PE psum_out
//  bus, whose column c arrives c cycles after column 0, and removes that diagonal skew. Each
//  re-aligned output row is buffered in a small FIFO and presented downstream on a valid/ready
//  interface. Issues a stall request so the array controller can drop enable_cycle before the
//  FIFO fills.
// PARAMETERS
//  COLS    8   array columns (number of psum lanes)
//  PSUM_W  32  partial-sum width per lane
//  DEPTH   4   row FIFO depth (entries, power of 2, >=2)
// PORTS
//  clk           in   1             clock
//  rst_n         in   1             async active-low reset
//  start         in   1             1-cycle pulse: begin draining a tile (sampled in IDLE only)
//  num_rows      in   8             rows to collect for this tile (sampled with start)
//  enable_cycle  in   1             array advance strobe; de-skew lines shift only when 1
//  in_valid      in   1             column-0 psum on col_psum is valid this cycle
//  col_psum      in   COLS*PSUM_W   bottom-row psum_out, lane c at [c*PSUM_W +: PSUM_W]
//  out_valid     out  1             FIFO head row valid
//  out_ready     in   1             downstream accepts row
//  out_row       out  COLS*PSUM_W   aligned row, same lane packing as col_psum
//  out_last      out  1             head row is last row of tile
//  stall_req     out  1             FIFO count >= DEPTH-1
//  busy          out  1             state != IDLE
//  done          out  1             1-cycle pulse: tile fully drained
//  overflow_err  out  1             sticky; cleared only by start or reset
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, delay lines 0, state IDLE.
//  De-skew: lane c goes through (COLS-1-c) registers; valid goes through COLS-1 registers.
//   All advance only when enable_cycle=1. With enable_cycle held 1, the row is written to the
//   FIFO exactly COLS-1 cycles after the column-0 in_valid beat. Lane COLS-1 needs no delay.
//  Push: occurs when aligned valid && enable_cycle && state==ACTIVE.
//   If the FIFO is full and there is no pop in the same cycle, the row is dropped and
//   overflow_err is set.
//   Simultaneous push and pop while full: both succeed and the count is unchanged.
//  Pop: out_valid && out_ready. out_row and out_last are stable while out_valid && !out_ready.
//  The row counter increments on every accepted push. A pushed row is tagged last when
//   counter==num_rows-1.
//  FSM:
//   IDLE --start--> ACTIVE. Counter, delay lines and overflow_err are cleared.
//    If num_rows==0, go IDLE with done next cycle.
//   ACTIVE --last row pushed--> FLUSH. in_valid beats arriving after the last row are ignored.
//   FLUSH --last row popped--> IDLE with done=1 for one cycle.
//  start outside IDLE is ignored. in_valid in IDLE is ignored and delay lines stay cleared.
//  Reset asserted mid-tile aborts immediately: FIFO contents are discarded and done is not
//   pulsed.
//  Data is a pure pass-through: no arithmetic and no width change.
// TESTING (COLS=4, DEPTH=4)
//  1. Aligned drain
//   Stimulus: num_rows=3, enable_cycle=1; in_valid beats at t0..t2, lane c carries 100*r+c
//    c cycles after beat r; out_ready=1.
//   Response: rows {100r+0..100r+3} appear at t0+3..t0+5; out_last on row 2; done after pop.
//  2. Backpressure
//   Stimulus: out_ready=0 for 6 rows, controller honours stall_req.
//   Response: stall_req high at count 3; no overflow; all rows delivered in order when
//    out_ready=1.
//  3. Overflow
//   Stimulus: ignore stall_req; push 6 rows with out_ready=0.
//   Response: 4 stored, overflow_err=1 sticky; the following start clears it.
//  4. Freeze
//   Stimulus: drop enable_cycle for 5 cycles mid-row.
//   Response: the row emerges intact, delayed by exactly 5 cycles.
//  5. Edge cases
//   Stimulus: num_rows=0 -> Response: done 1 cycle after start, busy pulse only.
//   Stimulus: start while busy -> Response: ignored.
//  6. Reset mid-tile
//   Stimulus: rst_n low with 2 rows in the FIFO.
//   Response: out_valid=0, busy=0, no done; a new tile afterwards drains correctly.

Source files
------------

// File: rtl/systolic_psum_drain.sv
// -----------------------------------------------------------------------------
// systolic_psum_drain
//
// South-edge drain for a weight-stationary systolic array. The bottom PE row
// emits its psum_out bus with a diagonal skew: lane c of a row arrives c array
// cycles after lane 0. This block delays each lane so that all lanes of a row
// line up. It buffers every re-aligned row in a small FIFO and presents the
// rows downstream on a valid/ready port.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         1-cycle pulse that begins a tile (honoured in IDLE only)
//   num_rows      rows in the tile, captured together with start
//   enable_cycle  array advance strobe; the de-skew lines shift only when 1
//   in_valid      lane-0 psum on col_psum is valid this cycle
//   col_psum      bottom-row psums, lane c at [c*PSUM_W +: PSUM_W]
//   out_valid     FIFO head row is valid
//   out_ready     downstream accepts the head row
//   out_row       head row, using the same lane packing as col_psum
//   out_last      head row is the last row of the tile
//   stall_req     FIFO holds DEPTH-1 or more rows; the controller should
//                 drop enable_cycle
//   busy          FSM is not IDLE
//   done          1-cycle pulse after the last row of the tile is popped
//   overflow_err  sticky flag: a row was dropped because the FIFO was full
//
// Handshake: a row transfers on every rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_row and out_last hold
// their values. out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
module systolic_psum_drain #(
  parameter int COLS   = 8,
  parameter int PSUM_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               num_rows,
  input  logic                     enable_cycle,
  input  logic                     in_valid,
  input  logic [COLS*PSUM_W-1:0]   col_psum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*PSUM_W-1:0]   out_row,
  output logic                     out_last,
  output logic                     stall_req,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = COLS * PSUM_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_e;

  state_e          state_q;
  logic [7:0]      num_rows_q;
  logic [7:0]      row_cnt_q;
  logic            done_q;
  logic            overflow_q;

  // ---------------------------------------------------------------------------
  // De-skew lines. These are held at zero in IDLE, so beats that arrive
  // outside a tile never reach the FIFO. In FLUSH the valid line still
  // shifts, but nothing is pushed.
  // ---------------------------------------------------------------------------
  logic [COLS-2:0] vld_q;
  logic [COLS-1:0] vld_shift;
  logic [RW-1:0]   aligned_row;
  logic            aligned_valid;

  assign vld_shift     = {vld_q, in_valid && (state_q == S_ACTIVE)};
  assign aligned_valid = vld_q[COLS-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (state_q == S_IDLE) begin
      vld_q <= '0;
    end else if (enable_cycle) begin
      vld_q <= vld_shift[COLS-2:0];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    if (c == COLS - 1) begin : g_pass
      // The last lane arrives last and needs no delay.
      assign aligned_row[c*PSUM_W +: PSUM_W] = col_psum[c*PSUM_W +: PSUM_W];
    end else begin : g_dly
      localparam int D = COLS - 1 - c;
      logic [PSUM_W-1:0] sr_q [D];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) sr_q[k] <= '0;
        end else if (state_q == S_IDLE) begin
          for (int k = 0; k < D; k++) sr_q[k] <= '0;
        end else if (enable_cycle) begin
          sr_q[0] <= col_psum[c*PSUM_W +: PSUM_W];
          for (int k = 1; k < D; k++) sr_q[k] <= sr_q[k-1];
        end
      end

      assign aligned_row[c*PSUM_W +: PSUM_W] = sr_q[D-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Row FIFO
  // ---------------------------------------------------------------------------
  logic [RW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] last_mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic push_req;
  logic push_ok;
  logic push_last;
  logic pop;
  logic full;

  assign full      = (count_q == CW'(DEPTH));
  assign pop       = (count_q != '0) && out_ready;
  assign push_req  = aligned_valid && enable_cycle && (state_q == S_ACTIVE);
  // When the FIFO is full, a pop in the same cycle frees the slot the push uses.
  assign push_ok   = push_req && (!full || pop);
  assign push_last = (row_cnt_q == (num_rows_q - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q]      <= aligned_row;
        last_mem_q[wr_ptr_q] <= push_last;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tile FSM: row counter, done pulse, sticky overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      num_rows_q <= '0;
      row_cnt_q  <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_ACTIVE;
            num_rows_q <= num_rows;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (num_rows_q == 8'd0) begin
            // An empty tile stays busy for one cycle and then reports done.
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else if (push_ok) begin
            row_cnt_q <= row_cnt_q + 8'd1;
            if (push_last) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (pop && last_mem_q[rd_ptr_q]) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign out_valid    = (count_q != '0);
  assign out_row      = mem_q[rd_ptr_q];
  assign out_last     = last_mem_q[rd_ptr_q];
  assign stall_req    = (count_q >= CW'(DEPTH - 1));
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_systolic_psum_drain.sv
// -----------------------------------------------------------------------------
// tb_systolic_psum_drain
//
// This bench uses directed steps for the psum drain with COLS=4 and DEPTH=4.
// The bench models the skewed array edge itself. Lane c of row r carries
// 100*r + c, and each lane is shown c advancing cycles after the lane-0 beat.
// Expected rows go into exp_q. Every transfer on the output port is compared
// against the head of exp_q.
// -----------------------------------------------------------------------------
module tb_systolic_psum_drain;

  localparam int COLS   = 4;
  localparam int PSUM_W = 32;
  localparam int DEPTH  = 4;
  localparam int W      = COLS * PSUM_W;

  typedef logic [W:0] cmp_t;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   num_rows;
  logic         enable_cycle;
  logic         in_valid;
  logic [W-1:0] col_psum;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_row;
  logic         out_last;
  logic         stall_req;
  logic         busy;
  logic         done;
  logic         overflow_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  systolic_psum_drain #(
    .COLS   (COLS),
    .PSUM_W (PSUM_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_rows     (num_rows),
    .enable_cycle (enable_cycle),
    .in_valid     (in_valid),
    .col_psum     (col_psum),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row      (out_row),
    .out_last     (out_last),
    .stall_req    (stall_req),
    .busy         (busy),
    .done         (done),
    .overflow_err (overflow_err)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   t0;
  int   first_valid_cyc;
  int   feed_next;
  int   feed_end;
  bit   done_seen;
  int   prev_row [COLS-1];   // row that entered lane 0 k+1 advances ago (-1 none)
  cmp_t exp_q [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [PSUM_W-1:0] lane_val(int r, int c);
    return PSUM_W'(100 * r + c);
  endfunction

  function automatic cmp_t exp_row(int r, bit last);
    cmp_t v;
    v = '0;
    for (int c = 0; c < COLS; c++) v[c*PSUM_W +: PSUM_W] = lane_val(r, c);
    v[W] = last;
    return v;
  endfunction

  task automatic chk(input string tag, input cmp_t obs, input cmp_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle of the skewed array edge plus scoreboard check
  // ---------------------------------------------------------------------------
  task automatic tick(input bit en, input bit beat, input int r);
    int rr;
    enable_cycle = en;
    in_valid     = en && beat;
    for (int c = 0; c < COLS; c++) begin
      rr = (c == 0) ? ((en && beat) ? r : -1) : prev_row[c-1];
      col_psum[c*PSUM_W +: PSUM_W] = (rr < 0) ? (32'hDEAD_0000 + 32'(c)) : lane_val(rr, c);
    end
    if (out_valid && out_ready) begin
      chk("sb_pending", cmp_t'(exp_q.size() > 0), cmp_t'(1));
      if (exp_q.size() > 0) chk("sb_row", {out_last, out_row}, exp_q.pop_front());
    end
    if (first_valid_cyc < 0 && out_valid) first_valid_cyc = cyc;
    @(posedge clk);
    if (en) begin
      for (int k = COLS - 2; k > 0; k--) prev_row[k] = prev_row[k-1];
      prev_row[0] = beat ? r : -1;
    end
    #1;
    cyc++;
    if (done) done_seen = 1'b1;
  endtask

  // Bounded run. It feeds any pending beats and can honour stall_req.
  task automatic run(input int max_cyc, input bit honour, input bit stop_done);
    for (int i = 0; i < max_cyc; i++) begin
      bit en;
      bit beat;
      en   = honour ? !stall_req : 1'b1;
      beat = en && (feed_next < feed_end);
      tick(en, beat, feed_next);
      if (beat) feed_next++;
      if (stop_done && done_seen) break;
    end
  endtask

  task automatic start_tile(input int n);
    start     = 1'b1;
    num_rows  = 8'(n);
    done_seen = 1'b0;
    tick(1'b1, 1'b0, 0);
    start     = 1'b0;
  endtask

  task automatic feed(input int first, input int n);
    feed_next = first;
    feed_end  = first + n;
  endtask

  task automatic expect_rows(input int first, input int n, input int last_idx);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_row(first + i, i == last_idx));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    num_rows     = '0;
    enable_cycle = 1'b0;
    in_valid     = 1'b0;
    col_psum     = '0;
    out_ready    = 1'b0;
    feed_next    = 0;
    feed_end     = 0;
    done_seen    = 1'b0;
    first_valid_cyc = -1;
    for (int k = 0; k < COLS - 1; k++) prev_row[k] = -1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", cmp_t'({out_valid, busy, done, stall_req, overflow_err, out_last}), '0);
    chk("reset_row", cmp_t'(out_row), '0);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 0);

    // 1. Aligned drain: 3 rows with out_ready high
    start_tile(3);
    chk("t1_busy", cmp_t'(busy), cmp_t'(1));
    out_ready = 1'b1;
    expect_rows(0, 3, 2);
    feed(0, 3);
    first_valid_cyc = -1;
    t0 = cyc;
    run(30, 1'b0, 1'b1);
    chk("t1_done", cmp_t'(done_seen), cmp_t'(1));
    // Written COLS-1 cycles after the beat, visible at the FIFO head one cycle later.
    chk("t1_latency", cmp_t'(first_valid_cyc), cmp_t'(t0 + COLS));
    chk("t1_idle", cmp_t'(busy), cmp_t'(0));
    chk("t1_drained", cmp_t'(exp_q.size()), cmp_t'(0));

    // 2. Backpressure: the controller honours stall_req
    start_tile(6);
    out_ready = 1'b0;
    expect_rows(10, 6, 5);
    feed(10, 6);
    run(20, 1'b1, 1'b0);
    chk("t2_stall", cmp_t'(stall_req), cmp_t'(1));
    chk("t2_no_ovf", cmp_t'(overflow_err), cmp_t'(0));
    chk("t2_valid", cmp_t'(out_valid), cmp_t'(1));
    out_ready = 1'b1;
    run(60, 1'b1, 1'b1);
    chk("t2_done", cmp_t'(done_seen), cmp_t'(1));
    chk("t2_drained", cmp_t'(exp_q.size()), cmp_t'(0));
    chk("t2_no_ovf_end", cmp_t'(overflow_err), cmp_t'(0));

    // 3. Overflow: stall_req is ignored; 6 rows go in, 4 are stored, 2 are dropped
    start_tile(8);
    out_ready = 1'b0;
    expect_rows(20, 4, -1);
    feed(20, 6);
    run(12, 1'b0, 1'b0);
    chk("t3_ovf", cmp_t'(overflow_err), cmp_t'(1));
    chk("t3_stall", cmp_t'(stall_req), cmp_t'(1));
    out_ready = 1'b1;
    run(8, 1'b0, 1'b0);
    chk("t3_empty", cmp_t'(out_valid), cmp_t'(0));
    chk("t3_sticky", cmp_t'(overflow_err), cmp_t'(1));
    chk("t3_busy", cmp_t'(busy), cmp_t'(1));
    // The counter stands at 4, so four more rows finish the tile.
    expect_rows(26, 4, 3);
    feed(26, 4);
    run(40, 1'b0, 1'b1);
    chk("t3_done", cmp_t'(done_seen), cmp_t'(1));
    chk("t3_drained", cmp_t'(exp_q.size()), cmp_t'(0));
    chk("t3_sticky_end", cmp_t'(overflow_err), cmp_t'(1));

    // 5a. Empty tile. This start also clears the overflow flag.
    start_tile(0);
    chk("t5_ovf_clr", cmp_t'(overflow_err), cmp_t'(0));
    chk("t5_busy_pulse", cmp_t'({busy, done}), cmp_t'(2'b10));
    tick(1'b1, 1'b0, 0);
    chk("t5_done", cmp_t'({busy, done}), cmp_t'(2'b01));
    tick(1'b1, 1'b0, 0);
    chk("t5_done_1cyc", cmp_t'(done), cmp_t'(0));

    // 4. Freeze: enable_cycle drops for 5 cycles in the middle of a row
    start_tile(1);
    out_ready = 1'b1;
    expect_rows(40, 1, 0);
    feed(0, 0);
    first_valid_cyc = -1;
    t0 = cyc;
    tick(1'b1, 1'b1, 40);
    tick(1'b1, 1'b0, 0);
    repeat (5) tick(1'b0, 1'b0, 0);
    run(30, 1'b0, 1'b1);
    chk("t4_done", cmp_t'(done_seen), cmp_t'(1));
    chk("t4_delay", cmp_t'(first_valid_cyc), cmp_t'(t0 + COLS + 5));
    chk("t4_drained", cmp_t'(exp_q.size()), cmp_t'(0));

    // 5b. A start while busy is ignored; the tile still ends after 2 rows.
    start_tile(2);
    expect_rows(50, 2, 1);
    feed(50, 2);
    run(3, 1'b0, 1'b0);
    start    = 1'b1;
    num_rows = 8'd5;
    run(1, 1'b0, 1'b0);
    start    = 1'b0;
    chk("t5b_busy", cmp_t'(busy), cmp_t'(1));
    run(40, 1'b0, 1'b1);
    chk("t5b_done", cmp_t'(done_seen), cmp_t'(1));
    chk("t5b_drained", cmp_t'(exp_q.size()), cmp_t'(0));
    chk("t5b_idle", cmp_t'(busy), cmp_t'(0));

    // 6. Reset mid-tile with 2 rows in the FIFO
    start_tile(4);
    out_ready = 1'b0;
    feed(60, 2);
    run(8, 1'b0, 1'b0);
    chk("t6_two_rows", cmp_t'({out_valid, stall_req}), cmp_t'(2'b10));
    rst_n = 1'b0;
    #1;
    chk("t6_abort", cmp_t'({out_valid, busy, done}), '0);
    for (int k = 0; k < COLS - 1; k++) prev_row[k] = -1;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    done_seen = 1'b0;
    tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b0, 0);
    chk("t6_no_done", cmp_t'(done_seen), cmp_t'(0));
    start_tile(2);
    out_ready = 1'b1;
    expect_rows(70, 2, 1);
    feed(70, 2);
    run(40, 1'b0, 1'b1);
    chk("t6_done", cmp_t'(done_seen), cmp_t'(1));
    chk("t6_drained", cmp_t'(exp_q.size()), cmp_t'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
